// File: rtl/cpl_pipelined_adder.sv
// Pipelined dual-rail adder: the carry ripples through STAGES register slices,
// and a valid/ready handshake moves the whole pipeline as a single unit.
module cpl_pipelined_adder #(
  parameter int WIDTH       = 16,
  parameter int STAGES      = 4,
  parameter bit CHECK_RAILS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Abar,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Bbar,
  input  logic             C,
  input  logic             Cbar,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] SumBar,
  output logic             Carry,
  output logic             CarryBar,
  output logic             out_rail_err,
  output logic             rail_err,
  input  logic             rail_err_clr
);

  localparam int SW = WIDTH / STAGES;

  logic             advance;
  logic             accept;
  logic             fault;
  logic [STAGES-1:0] stage_vld;
  logic [STAGES-1:0] stage_carry;
  logic [STAGES-1:0] stage_err;
  logic [WIDTH-1:0]  stage_a   [STAGES];
  logic [WIDTH-1:0]  stage_b   [STAGES];
  logic [WIDTH-1:0]  stage_sum [STAGES];

  // No bubble collapse: every slice moves only when the output slot is free.
  assign in_ready = ~stage_vld[STAGES-1] | out_ready;
  assign advance  = in_ready;
  assign accept   = in_valid & in_ready;

  generate
    if (CHECK_RAILS) begin : g_check
      logic rail_err_reg;

      assign fault = (|(A ~^ Abar)) | (|(B ~^ Bbar)) | (C ~^ Cbar);

      // A new fault takes priority over a clear arriving in the same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          rail_err_reg <= 1'b0;
        end else if (accept && fault) begin
          rail_err_reg <= 1'b1;
        end else if (rail_err_clr) begin
          rail_err_reg <= 1'b0;
        end
      end

      assign rail_err = rail_err_reg;
    end else begin : g_nocheck
      logic unused_rails;

      assign unused_rails = ^{Abar, Bbar, Cbar, rail_err_clr};
      assign fault        = 1'b0;
      assign rail_err     = 1'b0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             in_vld;
      logic             c_in;
      logic             err_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] sum_in;
      logic [SW:0]      slice;
      logic [WIDTH-1:0] sum_next;

      logic             vld_reg;
      logic             carry_reg;
      logic             err_reg;
      logic [WIDTH-1:0] sum_reg;
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;

      if (gi == 0) begin : g_first
        assign in_vld = accept;
        assign a_in   = A;
        assign b_in   = B;
        assign c_in   = C;
        assign err_in = fault;
        assign sum_in = '0;
      end else begin : g_later
        assign in_vld = stage_vld[gi-1];
        assign a_in   = stage_a[gi-1];
        assign b_in   = stage_b[gi-1];
        assign c_in   = stage_carry[gi-1];
        assign err_in = stage_err[gi-1];
        assign sum_in = stage_sum[gi-1];
      end

      assign slice = {1'b0, a_in[gi*SW +: SW]} + {1'b0, b_in[gi*SW +: SW]}
                   + {{SW{1'b0}}, c_in};

      // Finished low bits ride along unchanged; this slice fills in its own bits.
      always_comb begin
        sum_next                = sum_in;
        sum_next[gi*SW +: SW]   = slice[SW-1:0];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_reg   <= 1'b0;
          carry_reg <= 1'b0;
          err_reg   <= 1'b0;
          sum_reg   <= '0;
        end else if (advance) begin
          vld_reg <= in_vld;
          if (in_vld) begin
            carry_reg <= slice[SW];
            err_reg   <= err_in;
            sum_reg   <= sum_next;
          end
        end
      end

      // Operand skew registers carry no reset: contents only matter under vld_reg.
      always_ff @(posedge clk) begin
        if (advance && in_vld) begin
          a_reg <= a_in;
          b_reg <= b_in;
        end
      end

      assign stage_vld[gi]   = vld_reg;
      assign stage_carry[gi] = carry_reg;
      assign stage_err[gi]   = err_reg;
      assign stage_sum[gi]   = sum_reg;
      assign stage_a[gi]     = a_reg;
      assign stage_b[gi]     = b_reg;
    end
  endgenerate

  logic unused_ops;
  assign unused_ops = ^{stage_a[STAGES-1], stage_b[STAGES-1]};

  assign out_valid    = stage_vld[STAGES-1];
  assign Sum          = stage_sum[STAGES-1];
  assign SumBar       = ~stage_sum[STAGES-1];
  assign Carry        = stage_carry[STAGES-1];
  assign CarryBar     = ~stage_carry[STAGES-1];
  assign out_rail_err = stage_err[STAGES-1];

endmodule

// File: tb/tb_cpl_pipelined_adder.sv
// Randomized bench for cpl_pipelined_adder, checking it against a plain arithmetic
// model: latency, carry chain, streaming, backpressure, rail faults and reset.
module tb_cpl_pipelined_adder;
  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W:0] val;
    logic [W:0] bar;
    logic       err;
    int         cyc;
  } res_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, abar, b, bbar;
  logic         c, cbar;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum, SumBar;
  logic         Carry, CarryBar;
  logic         out_rail_err;
  logic         rail_err;
  logic         rail_err_clr;

  int   n_run  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  res_t exp_q[$];
  res_t got_q[$];

  cpl_pipelined_adder #(.WIDTH(W), .STAGES(S), .CHECK_RAILS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .Abar(abar), .B(b), .Bbar(bbar), .C(c), .Cbar(cbar),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .SumBar(SumBar), .Carry(Carry), .CarryBar(CarryBar),
    .out_rail_err(out_rail_err), .rail_err(rail_err), .rail_err_clr(rail_err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog");
  end

  // Reference: exact integer sum; a fault is any rail pair that is not complementary.
  function automatic res_t model(input logic [W-1:0] av, abv, bv, bbv, input logic cv, cbv);
    res_t r;
    r.val = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    r.bar = ~r.val;
    r.err = ((av ^ abv) != {W{1'b1}}) || ((bv ^ bbv) != {W{1'b1}}) || (cv == cbv);
    r.cyc = 0;
    return r;
  endfunction

  // Advance one clock; records accepted operands and delivered results.
  task automatic tick(output bit acc);
    res_t r;
    #2;
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(a, abar, b, bbar, c, cbar));
    if (out_valid && out_ready) begin
      r.val = {Carry, Sum};
      r.bar = {CarryBar, SumBar};
      r.err = out_rail_err;
      r.cyc = cyc;
      got_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_clean();
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    abar = ~a; bbar = ~b; cbar = ~c;
  endtask

  task automatic drain(input int n);
    bit acc;
    int k = 0;
    in_valid = 1'b0;
    while (got_q.size() < n && k < 60) begin
      tick(acc);
      k++;
    end
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rail_err_clr = 1'b0;
    drive_clean();
    tick(acc); tick(acc);
    rst = 1'b0;
    #1;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_run++; if (Sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got=%h want=0000", Sum); end
    n_run++; if (SumBar !== 16'hFFFF) begin n_fail++; $display("FAIL reset_sumbar got=%h want=ffff", SumBar); end
    n_run++; if (Carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got=%b want=0", Carry); end
    n_run++; if (CarryBar !== 1'b1) begin n_fail++; $display("FAIL reset_carrybar got=%b want=1", CarryBar); end
    n_run++; if (out_rail_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_rail_err got=%b want=0", out_rail_err); end
    n_run++; if (rail_err !== 1'b0) begin n_fail++; $display("FAIL reset_rail_err got=%b want=0", rail_err); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_single();
    bit acc;
    int lat;
    a = 16'h00FF; abar = ~a; b = 16'h0001; bbar = ~b; c = 1'b0; cbar = 1'b1;
    in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    n_run++; if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept got=%b want=1", acc); end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick(acc);
      lat++;
    end
    n_run++; if (lat !== S) begin n_fail++; $display("FAIL single_latency got=%0d want=%0d", lat, S); end
    n_run++; if (Sum !== 16'h0100) begin n_fail++; $display("FAIL single_sum got=%h want=0100", Sum); end
    n_run++; if (SumBar !== 16'hFEFF) begin n_fail++; $display("FAIL single_sumbar got=%h want=feff", SumBar); end
    n_run++; if ({Carry, CarryBar} !== 2'b01) begin n_fail++; $display("FAIL single_carry got=%b%b want=01", Carry, CarryBar); end
    n_run++; if (out_rail_err !== 1'b0) begin n_fail++; $display("FAIL single_rail_err got=%b want=0", out_rail_err); end
    $display("[TB] single: A=00ff B=0001 C=0 -> Sum=%h Carry=%b latency=%0d", Sum, Carry, lat);
    tick(acc);
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_carry_chain();
    bit acc;
    in_valid = 1'b1;
    a = 16'hFFFF; abar = ~a; b = 16'h0000; bbar = ~b; c = 1'b1; cbar = 1'b0;
    tick(acc);
    a = 16'hFFFF; abar = ~a; b = 16'hFFFF; bbar = ~b; c = 1'b1; cbar = 1'b0;
    tick(acc);
    drain(2);
    n_run++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL carry_count got=%0d want=2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_run++; if (got_q[0].val !== 17'h10000) begin n_fail++; $display("FAIL carry_overflow got=%h want=10000", got_q[0].val); end
      n_run++; if (got_q[0].bar !== 17'h0FFFF) begin n_fail++; $display("FAIL carry_overflow_bar got=%h want=0ffff", got_q[0].bar); end
      n_run++; if (got_q[1].val !== 17'h1FFFF) begin n_fail++; $display("FAIL carry_full got=%h want=1ffff", got_q[1].val); end
      n_run++; if (got_q[1].bar !== 17'h00000) begin n_fail++; $display("FAIL carry_full_bar got=%h want=00000", got_q[1].bar); end
      for (int i = 0; i < 2; i++)
        $display("[TB] carry txn %0d: {Carry,Sum}=%h", i, got_q[i].val);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    bit acc;
    for (int i = 0; i < 8; i++) begin
      drive_clean();
      in_valid = 1'b1;
      tick(acc);
    end
    drain(8);
    n_run++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL b2b_count got=%0d want=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
      $display("[TB] b2b txn %0d: got=%h want=%h err=%b", i, got_q[i].val, exp_q[i].val, got_q[i].err);
      n_run++; if (got_q[i].val !== exp_q[i].val) begin n_fail++; $display("FAIL b2b_sum[%0d] got=%h want=%h", i, got_q[i].val, exp_q[i].val); end
      n_run++; if (got_q[i].bar !== ~exp_q[i].val) begin n_fail++; $display("FAIL b2b_bar[%0d] got=%h want=%h", i, got_q[i].bar, ~exp_q[i].val); end
      n_run++; if (got_q[i].cyc !== got_q[0].cyc + i) begin n_fail++; $display("FAIL b2b_cycle[%0d] got=%0d want=%0d", i, got_q[i].cyc, got_q[0].cyc + i); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    bit           acc;
    int           idx = 0;
    int           t = 0;
    logic [W-1:0] held;
    logic [W-1:0] ops_a [10];
    logic [W-1:0] ops_b [10];
    logic         ops_c [10];
    for (int i = 0; i < 10; i++) begin
      ops_a[i] = W'($urandom); ops_b[i] = W'($urandom); ops_c[i] = 1'($urandom);
    end
    held = '0;
    while (idx < 10 && t < 60) begin
      a = ops_a[idx]; abar = ~a; b = ops_b[idx]; bbar = ~b; c = ops_c[idx]; cbar = ~c;
      in_valid  = 1'b1;
      out_ready = !(t >= 6 && t < 11);
      #1;
      if (t == 6) held = Sum;
      if (t >= 6 && t < 11) begin
        n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready t=%0d got=%b want=0", t, in_ready); end
      end
      if (t >= 7 && t <= 11) begin
        n_run++; if (Sum !== held) begin n_fail++; $display("FAIL stall_hold t=%0d got=%h want=%h", t, Sum, held); end
      end
      tick(acc);
      if (acc) idx++;
      t++;
    end
    out_ready = 1'b1;
    drain(10);
    n_run++; if (got_q.size() !== 10) begin n_fail++; $display("FAIL bp_count got=%0d want=10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      $display("[TB] bp txn %0d: got=%h want=%h", i, got_q[i].val, exp_q[i].val);
      n_run++; if (got_q[i].val !== exp_q[i].val) begin n_fail++; $display("FAIL bp_sum[%0d] got=%h want=%h", i, got_q[i].val, exp_q[i].val); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_rail_fault();
    bit acc;
    n_run++; if (rail_err !== 1'b0) begin n_fail++; $display("FAIL fault_pre got=%b want=0", rail_err); end
    a = 16'h1234; abar = 16'hEDCA; b = W'($urandom); bbar = ~b; c = 1'($urandom); cbar = ~c;
    in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    n_run++; if (rail_err !== 1'b1) begin n_fail++; $display("FAIL fault_set got=%b want=1", rail_err); end
    drain(1);
    n_run++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL fault_count got=%0d want=1", got_q.size()); end
    if (got_q.size() == 1) begin
      $display("[TB] fault txn: got=%h want=%h err=%b", got_q[0].val, exp_q[0].val, got_q[0].err);
      n_run++; if (got_q[0].val !== exp_q[0].val) begin n_fail++; $display("FAIL fault_sum got=%h want=%h", got_q[0].val, exp_q[0].val); end
      n_run++; if (got_q[0].err !== 1'b1) begin n_fail++; $display("FAIL fault_out_err got=%b want=1", got_q[0].err); end
    end
    exp_q.delete(); got_q.delete();
    rail_err_clr = 1'b1;
    tick(acc);
    n_run++; if (rail_err !== 1'b0) begin n_fail++; $display("FAIL fault_clear got=%b want=0", rail_err); end
    drive_clean();
    bbar[5] = b[5];
    in_valid = 1'b1;
    tick(acc);
    n_run++; if (rail_err !== 1'b1) begin n_fail++; $display("FAIL fault_set_wins got=%b want=1", rail_err); end
    drive_clean();
    tick(acc);
    in_valid = 1'b0; rail_err_clr = 1'b0;
    n_run++; if (rail_err !== 1'b0) begin n_fail++; $display("FAIL fault_clean_clear got=%b want=0", rail_err); end
    drain(2);
    n_run++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL fault2_count got=%0d want=2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      $display("[TB] fault2 txn %0d: got=%h err=%b want=%h err=%b", i, got_q[i].val, got_q[i].err, exp_q[i].val, exp_q[i].err);
      n_run++; if ({got_q[i].err, got_q[i].val} !== {exp_q[i].err, exp_q[i].val}) begin n_fail++; $display("FAIL fault2[%0d] got=%b/%h want=%b/%h", i, got_q[i].err, got_q[i].val, exp_q[i].err, exp_q[i].val); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_inflight();
    bit acc;
    for (int i = 0; i < 4; i++) begin
      drive_clean();
      in_valid = 1'b1;
      tick(acc);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    n_run++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL rstfl_delivered got=%0d want=1", got_q.size()); end
    if (got_q.size() >= 1 && exp_q.size() >= 1) begin
      n_run++; if (got_q[0].val !== exp_q[0].val) begin n_fail++; $display("FAIL rstfl_first got=%h want=%h", got_q[0].val, exp_q[0].val); end
    end
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_out_valid got=%b want=0", out_valid); end
    n_run++; if (Sum !== 16'h0000) begin n_fail++; $display("FAIL rstfl_sum got=%h want=0000", Sum); end
    n_run++; if (SumBar !== 16'hFFFF) begin n_fail++; $display("FAIL rstfl_sumbar got=%h want=ffff", SumBar); end
    n_run++; if ({Carry, CarryBar} !== 2'b01) begin n_fail++; $display("FAIL rstfl_carry got=%b%b want=01", Carry, CarryBar); end
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 10; i++) tick(acc);
    n_run++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rstfl_stale got=%0d want=0", got_q.size()); end
    $display("[TB] reset in flight: stale results after reset=%0d", got_q.size());
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; rail_err_clr = 1'b0;
    a = '0; abar = '1; b = '0; bbar = '1; c = 1'b0; cbar = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_rail_fault();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/cpl_pipelined_adder.md
Name: cpl_pipelined_adder

Overview:
Parametrised, pipelined successor to the single-bit dual-rail CPL full adder. Adds two WIDTH-bit dual-rail operands plus a dual-rail carry-in. The carry ripples through STAGES register slices, and each slice adds WIDTH/STAGES bits. It produces dual-rail Sum/Cout, uses a valid/ready handshake and checks rail consistency on every accepted operand. It sits between the operand register file and the datapath consumers that expect complementary rails.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline slices and the latency in cycles; 1..WIDTH.
CHECK_RAILS, 1, 1 = rail-consistency checker present; 0 = rail_err and out_rail_err tied 0.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand set valid.
in_ready  output  1  block can accept operands this cycle.
A  input  WIDTH  operand A, true rail.
Abar  input  WIDTH  operand A, complement rail.
B  input  WIDTH  operand B, true rail.
Bbar  input  WIDTH  operand B, complement rail.
C  input  1  carry-in, true rail.
Cbar  input  1  carry-in, complement rail.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
Sum  output  WIDTH  sum, true rail.
SumBar  output  WIDTH  sum, complement rail.
Carry  output  1  carry-out, true rail.
CarryBar  output  1  carry-out, complement rail.
out_rail_err  output  1  rail fault seen on the operands of the current result.
rail_err  output  1  sticky rail-fault flag.
rail_err_clr  input  1  clears rail_err.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset values: all stage valids 0, out_valid=0, Sum=0, SumBar=all ones, Carry=0, CarryBar=1, out_rail_err=0, rail_err=0.
- Reset mid-operation discards every in-flight result; no partial output appears.
- Accept: an operand set is taken when in_valid & in_ready.
- Ready: in_ready = ~out_valid | out_ready. The whole pipeline advances or stalls together; there is no bubble collapse.
- Stall: while out_valid & ~out_ready, every stage register, Sum/Carry and out_rail_err hold.
- Datapath uses the true rails only (A, B, C); the complement rails are used only by the checker.
- Stage k (0..STAGES-1) adds bits [k*W/S +: W/S] with the carry registered from stage k-1. Stage 0 uses C as its carry-in.
- Operand bits for later slices are skew-delayed; completed sum bits are deskewed.
- Latency: exactly STAGES cycles from accept to out_valid, with no stalls. Throughput is 1 result per cycle.
- Arithmetic: {Carry,Sum} = A + B + C, modulo 2^(WIDTH+1).
- Dual-rail invariant: SumBar == ~Sum and CarryBar == ~Carry on every cycle, including reset and stall.
- Rail checker, evaluated at accept: fault = any A[i]==Abar[i], any B[i]==Bbar[i], or C==Cbar.
  - The fault bit travels with its transaction and appears as out_rail_err alongside that result.
  - The result is still computed from the true rails.
- rail_err is set in the accept cycle of a faulted operand set. It clears on rail_err_clr. If set and clear occur in the same cycle, set wins.
- Input values are ignored when in_valid=0 or in_ready=0; stage data is don't-care when its valid is 0, but outputs hold their last values.
- STAGES==1: single registered adder, latency 1.
- STAGES==WIDTH: one bit per slice, latency WIDTH.

Test Plan:
- Reset, then a single add A=0x00FF, B=0x0001, C=0 (clean rails) → out_valid exactly 4 cycles later; Sum=0x0100, SumBar=0xFEFF, Carry=0, CarryBar=1, out_rail_err=0.
- Overflow and full carry chain: A=0xFFFF, B=0x0000, C=1 → Sum=0x0000, Carry=1, CarryBar=0. Then A=0xFFFF, B=0xFFFF, C=1 → Sum=0xFFFF, Carry=1.
- Back-to-back stream of 8 random operand sets with out_ready=1 → 8 consecutive out_valid cycles, in order, each equal to the reference sum.
- Backpressure: out_ready=0 for 5 cycles mid-stream → in_ready=0 during the stall, outputs hold. After release, results continue with no loss or duplication.
- Rail fault: A=0x1234 with Abar=0xEDCA (bit 0 not complementary) → the result Sum matches the A+B+C sum and out_rail_err=1 with it, and rail_err goes high in the accept cycle. Asserting rail_err_clr in the same cycle as a new fault keeps rail_err=1.
- Reset asserted with 3 results in flight → next cycle out_valid=0, Sum=0, SumBar=0xFFFF. No stale result emerges afterwards.
